// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard sequencer: set-2 scan-code
// constants, the pop FSM state encoding and the queued key-event record.
package ps2_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERRF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } ps2_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  // Keyboard reports internal errors / buffer overrun with 00 or FF.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERRF);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO between the decode FSM and the CPU-side register block.
// Wrap-bit pointers give full/empty without an occupancy counter. The head
// output shows the entry at the read pointer; while empty it keeps showing
// the last head so software reading stale fields sees a stable value.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     clrn,
  input  logic     push,
  input  ps2_evt_t push_evt,
  input  logic     pop,
  output ps2_evt_t head,
  output logic     full,
  output logic     empty,
  output logic     drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ps2_evt_t       mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  ps2_evt_t       hold_q, hold_d;
  logic           wr_en;
  logic           rd_en;

  // Flags, pointer advance and head selection.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wr_en    = push && !full;
    drop     = push && full;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    hold_d   = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
    head     = hold_d;
  end

  // Pointer and held-head registers.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
    end
  end

  // Storage; only ever read while non-empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_evt;
  end

endmodule

// File: rtl/ps2_kbd_sequencer.sv
// PS/2 keyboard sequencer: pops bytes from the receiver FIFO one at a time
// (IDLE -> POP -> SETTLE), folds E0/F0 prefixes into key events, queues them
// for the CPU side, counts make events and keeps sticky error/overflow flags.
// Optional: define TYPEMATIC_FILTER_EN to discard auto-repeated make events.
module ps2_kbd_sequencer
  import ps2_pkg::*;
#(
  parameter int EVT_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             kb_ready,
  input  logic [7:0]       kb_data,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic [CNT_W-1:0] make_cnt,
  output logic             err_sticky,
  output logic             ovf_sticky,
  input  logic             err_clr
);

  ps2_state_t       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [CNT_W-1:0] make_cnt_q, make_cnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             err_set;
  logic             push;
  ps2_evt_t         push_evt;
  ps2_evt_t         fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
`ifdef TYPEMATIC_FILTER_EN
  logic [8:0]       last_make_q, last_make_d;
  logic             last_vld_q, last_vld_d;
  logic             repeat_make;
`endif

  ps2_evt_fifo #(
    .DEPTH(EVT_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push    (push),
    .push_evt(push_evt),
    .pop     (evt_valid && evt_ready),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  // Pop sequencing, prefix decode, event push and make counting.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    nextdata_n_d = 1'b1;
    ext_d        = ext_q;
    brk_d        = brk_q;
    make_cnt_d   = make_cnt_q;
    err_set      = 1'b0;
    push         = 1'b0;
    push_evt     = '{code: byte_q, ext: ext_q, brk: brk_q};
`ifdef TYPEMATIC_FILTER_EN
    last_make_d  = last_make_q;
    last_vld_d   = last_vld_q;
    repeat_make  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Prefixes also wait for space so a whole key sequence never stalls
        // halfway with its final byte unable to land.
        if (kb_ready && !fifo_full) begin
          byte_d       = kb_data;
          nextdata_n_d = 1'b0;
          state_d      = POP;
        end
      end
      POP: begin
        state_d = SETTLE;
        if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == SC_BRK) begin
          brk_d = 1'b1;
        end else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (is_err_byte(byte_q)) begin
            err_set = 1'b1;
          end else begin
`ifdef TYPEMATIC_FILTER_EN
            repeat_make = !brk_q && last_vld_q && (last_make_q == {byte_q, ext_q});
            if (!brk_q && !repeat_make) begin
              last_make_d = {byte_q, ext_q};
              last_vld_d  = 1'b1;
            end
            if (brk_q && last_vld_q && (last_make_q == {byte_q, ext_q}))
              last_vld_d = 1'b0;
            push = !repeat_make;
`else
            push = 1'b1;
`endif
            if (push && !fifo_full && !brk_q)
              make_cnt_d = make_cnt_q + CNT_W'(1);
          end
        end
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: a set condition beats a simultaneous clear.
  always_comb begin
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    ovf_d = (kb_overflow || fifo_drop) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
  end

  // Control state; reset mid-pop releases the strobe before the receiver pops.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q      <= IDLE;
      nextdata_n_q <= 1'b1;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      make_cnt_q   <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef TYPEMATIC_FILTER_EN
      last_vld_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      make_cnt_q   <= make_cnt_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
`ifdef TYPEMATIC_FILTER_EN
      last_vld_q   <= last_vld_d;
`endif
    end
  end

  // Captured byte (and last make key); qualified by state / valid bit.
  always_ff @(posedge clk) begin
    byte_q      <= byte_d;
`ifdef TYPEMATIC_FILTER_EN
    last_make_q <= last_make_d;
`endif
  end

  assign kb_nextdata_n = nextdata_n_q;
  assign evt_valid     = !fifo_empty;
  assign evt_code      = fifo_head.code;
  assign evt_ext       = fifo_head.ext;
  assign evt_brk       = fifo_head.brk;
  assign make_cnt      = make_cnt_q;
  assign err_sticky    = err_q;
  assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_sequencer.sv
// Directed bench for ps2_kbd_sequencer with a queue-based receiver model
// and an always-ready/stallable consumer that logs accepted events.
module tb_ps2_kbd_sequencer;

  localparam int EVT_DEPTH = 4;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             clrn = 1'b1;
  logic             kb_ready = 1'b0;
  logic [7:0]       kb_data = 8'h00;
  logic             kb_overflow = 1'b0;
  logic             evt_ready = 1'b0;
  logic             err_clr = 1'b0;
  logic             kb_nextdata_n;
  logic             evt_valid;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_brk;
  logic [CNT_W-1:0] make_cnt;
  logic             err_sticky;
  logic             ovf_sticky;

  int checks   = 0;
  int failures = 0;
  int npops    = 0;
  int low_run  = 0;
  int max_low  = 0;
  int p0;
  int lows;
  logic seen;

  logic [7:0] rx_q[$];
  logic [9:0] got_q[$];

  always #5 clk = ~clk;

  ps2_kbd_sequencer #(
    .EVT_DEPTH(EVT_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .kb_ready     (kb_ready),
    .kb_data      (kb_data),
    .kb_overflow  (kb_overflow),
    .kb_nextdata_n(kb_nextdata_n),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_brk      (evt_brk),
    .make_cnt     (make_cnt),
    .err_sticky   (err_sticky),
    .ovf_sticky   (ovf_sticky),
    .err_clr      (err_clr)
  );

  // Receiver model: pops on the strobe, presents the new head afterwards.
  always @(negedge clk) begin
    if (!kb_nextdata_n && rx_q.size() > 0) begin
      void'(rx_q.pop_front());
      npops <= npops + 1;
    end
    kb_ready <= (rx_q.size() > 0);
    kb_data  <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Consumer log and strobe-width monitor.
  always @(posedge clk) begin
    if (evt_valid && evt_ready) got_q.push_back({evt_code, evt_ext, evt_brk});
    if (!kb_nextdata_n) begin
      low_run <= low_run + 1;
      if (low_run + 1 > max_low) max_low <= low_run + 1;
    end else begin
      low_run <= 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 10'h3FF;
  endfunction

  initial begin
    // Reset state
    step(2);
    check("rst_nextdata_n", kb_nextdata_n, 1);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_fields", {evt_code, evt_ext, evt_brk}, 0);
    check("rst_make_cnt", make_cnt, 0);
    check("rst_flags", {err_sticky, ovf_sticky}, 0);
    clrn = 1'b0;
    step(2);

    // Make key 1C
    evt_ready = 1'b1;
    rx_q.push_back(8'h1C);
    step(10);
    check("make_pops", npops, 1);
    check("make_nevt", got_q.size(), 1);
    check("make_evt", got_at(0), {8'h1C, 1'b0, 1'b0});
    check("make_cnt1", make_cnt, 1);

    // Extended release, both prefix orders
    got_q.delete();
    p0 = npops;
    rx_q.push_back(8'hE0); rx_q.push_back(8'hF0); rx_q.push_back(8'h75);
    step(15);
    check("extrel_pops", npops - p0, 3);
    check("extrel_nevt", got_q.size(), 1);
    check("extrel_evt", got_at(0), {8'h75, 1'b1, 1'b1});
    check("extrel_cnt", make_cnt, 1);
    rx_q.push_back(8'hF0); rx_q.push_back(8'hE0); rx_q.push_back(8'h74);
    step(15);
    check("brkext_evt", got_at(1), {8'h74, 1'b1, 1'b1});

    // Backpressure: 6 bytes, depth 4
    got_q.delete();
    evt_ready = 1'b0;
    p0 = npops;
    rx_q.push_back(8'h15); rx_q.push_back(8'h16); rx_q.push_back(8'h1E);
    rx_q.push_back(8'h26); rx_q.push_back(8'h25); rx_q.push_back(8'h2E);
    step(30);
    check("bp_valid", evt_valid, 1);
    check("bp_head", evt_code, 8'h15);
    check("bp_pops", npops - p0, 4);
    check("bp_kb_ready", kb_ready, 1);
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (!kb_nextdata_n) lows++;
    end
    check("bp_stall_lows", lows, 0);
    evt_ready = 1'b1;
    step(30);
    check("bp_nevt", got_q.size(), 6);
    check("bp_e0", got_at(0), {8'h15, 2'b00});
    check("bp_e1", got_at(1), {8'h16, 2'b00});
    check("bp_e2", got_at(2), {8'h1E, 2'b00});
    check("bp_e3", got_at(3), {8'h26, 2'b00});
    check("bp_e4", got_at(4), {8'h25, 2'b00});
    check("bp_e5", got_at(5), {8'h2E, 2'b00});
    check("bp_ovf", ovf_sticky, 0);
    check("bp_cnt", make_cnt, 7);
    check("bp_empty_valid", evt_valid, 0);
    check("bp_empty_hold", evt_code, 8'h2E);

    // Error bytes and flags
    got_q.delete();
    rx_q.push_back(8'hFF);
    step(8);
    check("err_ff_set", err_sticky, 1);
    check("err_ff_noevt", got_q.size(), 0);
    rx_q.push_back(8'hE0); rx_q.push_back(8'hFF); rx_q.push_back(8'h1C);
    step(15);
    check("err_clears_prefix", got_at(0), {8'h1C, 2'b00});
    check("err_cnt", make_cnt, 8);
    kb_overflow = 1'b1;
    step(1);
    kb_overflow = 1'b0;
    check("ovf_set", ovf_sticky, 1);
    step(1);
    err_clr = 1'b1;
    kb_overflow = 1'b1;
    step(1);
    err_clr = 1'b0;
    kb_overflow = 1'b0;
    check("ovf_set_wins", ovf_sticky, 1);
    check("err_cleared", err_sticky, 0);
    rx_q.push_back(8'h00);
    step(8);
    check("err_00_set", err_sticky, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("clr_both", {err_sticky, ovf_sticky}, 0);

    // Reset during POP with stale prefixes pending
    rx_q.push_back(8'hE0); rx_q.push_back(8'hF0);
    step(10);
    rx_q.push_back(8'h1C);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (!kb_nextdata_n) seen = 1'b1;
    end
    check("rst_pop_seen", seen, 1);
    clrn = 1'b1;
    #1;
    check("rstpop_nextdata_n", kb_nextdata_n, 1);
    check("rstpop_valid", evt_valid, 0);
    check("rstpop_cnt", make_cnt, 0);
    step(2);
    check("rstpop_rx_kept", rx_q.size(), 1);
    got_q.delete();
    clrn = 1'b0;
    step(12);
    check("rstpop_evt", got_at(0), {8'h1C, 2'b00});
    check("rstpop_nevt", got_q.size(), 1);
    check("rstpop_cnt1", make_cnt, 1);

    // Typematic sequence from a clean reset
    clrn = 1'b1;
    step(2);
    clrn = 1'b0;
    got_q.delete();
    step(1);
    rx_q.push_back(8'h1C); rx_q.push_back(8'h1C); rx_q.push_back(8'h1C);
    rx_q.push_back(8'hF0); rx_q.push_back(8'h1C); rx_q.push_back(8'h1C);
    step(40);
`ifdef TYPEMATIC_FILTER_EN
    check("tm_nevt", got_q.size(), 3);
    check("tm_e0", got_at(0), {8'h1C, 2'b00});
    check("tm_e1", got_at(1), {8'h1C, 2'b01});
    check("tm_e2", got_at(2), {8'h1C, 2'b00});
    check("tm_cnt", make_cnt, 2);
`else
    check("tm_nevt", got_q.size(), 5);
    check("tm_e2", got_at(2), {8'h1C, 2'b00});
    check("tm_e3", got_at(3), {8'h1C, 2'b01});
    check("tm_e4", got_at(4), {8'h1C, 2'b00});
    check("tm_cnt", make_cnt, 4);
`endif

    check("strobe_width", max_low, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
